// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch stage between pc_reg and decode.
//
// Issues the current PC as an instruction-memory read whenever a credit is
// free (queued + in-flight < DEPTH). In-order responses are paired with the
// address recorded at issue time (tag FIFO) and buffered in a circular queue
// that feeds decode over a valid/ready handshake. A jump flushes the queue
// and schedules the still in-flight responses to be discarded.
//
// Optional feature: define FETCH_BYPASS_EN to present a response to decode
// in the cycle it arrives when the queue is empty (latency L instead of L+1).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_i              current PC from pc_reg
//   jump_flag_i       taken jump/branch, flushes the stage this cycle
//   req_valid_o       instruction-memory read request
//   req_addr_o        request address (= pc_i)
//   req_ready_i       memory accepts the request
//   rsp_valid_i       read data valid (in request order, max one per cycle)
//   rsp_data_i        read data
//   fetch_stall_o     PC not consumed this cycle (hold for pc_reg)
//   inst_valid_o      queue head valid
//   inst_o            head instruction, NOP (0x00000013) when not valid
//   inst_addr_o       head instruction address, 0 when not valid
//   id_ready_i        decode accepts the head
module if_fetch #(
    parameter int DEPTH = 4  // power of two, 2..8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        jump_flag_i,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    input  logic        req_ready_i,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    output logic        fetch_stall_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        id_ready_i
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [CW-1:0] count;        // valid queue entries
    logic [CW-1:0] outstanding;  // accepted requests awaiting a response
    logic [CW-1:0] drop;         // responses to discard after a flush
    logic [AW-1:0] head, tail, tag_wr, tag_rd;
    logic [31:0]   tag_mem [DEPTH];
    logic [31:0]   q_addr  [DEPTH];
    logic [31:0]   q_inst  [DEPTH];

    logic          accept, rsp_ok, keep, byp, push, pop_q;
    logic [CW:0]   used;

    // Credit check uses registered counters only, so id_ready_i never
    // reaches req_valid_o combinationally.
    assign used          = {1'b0, count} + {1'b0, outstanding};
    assign req_valid_o   = !rst && !jump_flag_i && (used < (CW+1)'(DEPTH));
    assign req_addr_o    = pc_i;
    assign accept        = req_valid_o && req_ready_i;
    assign fetch_stall_o = !accept;

    // A response with nothing outstanding is a protocol error: ignored.
    assign rsp_ok = !rst && rsp_valid_i && (outstanding != '0);
    // Response that survives: not owed to an earlier flush, not in a flush cycle.
    assign keep   = rsp_ok && (drop == '0) && !jump_flag_i;

`ifdef FETCH_BYPASS_EN
    assign byp = keep && (count == '0);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = NOP;
        inst_addr_o  = '0;
        if (!rst && !jump_flag_i) begin
            if (count != '0) begin
                inst_valid_o = 1'b1;
                inst_o       = q_inst[head];
                inst_addr_o  = q_addr[head];
            end else if (byp) begin
                inst_valid_o = 1'b1;
                inst_o       = rsp_data_i;
                inst_addr_o  = tag_mem[tag_rd];
            end
        end
    end

    assign pop_q = inst_valid_o && id_ready_i && (count != '0);
    // A bypassed response consumed by decode never enters the queue.
    assign push  = keep && !(byp && id_ready_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            head        <= '0;
            tail        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
                q_addr[i]  <= '0;
                q_inst[i]  <= NOP;
            end
        end else begin
            if (accept) begin
                tag_mem[tag_wr] <= pc_i;
                tag_wr          <= tag_wr + AW'(1);
            end
            // Every counted response pops its tag, dropped or not, so tags
            // stay aligned across flushes.
            if (rsp_ok)
                tag_rd <= tag_rd + AW'(1);
            if (push) begin
                q_addr[tail] <= tag_mem[tag_rd];
                q_inst[tail] <= rsp_data_i;
                tail         <= tail + AW'(1);
            end
            outstanding <= outstanding + CW'(accept) - CW'(rsp_ok);
            if (jump_flag_i) begin
                // No push or pop in a flush cycle; empty the queue in place.
                count <= '0;
                head  <= tail;
                drop  <= outstanding - CW'(rsp_ok);
            end else begin
                if (pop_q)
                    head <= head + AW'(1);
                count <= count + CW'(push) - CW'(pop_q);
                if (rsp_ok && (drop != '0))
                    drop <= drop - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: randomized stimulus with a queue-based reference
// model (accepted addresses owed to decode, plus a memory model holding
// in-flight reads tagged live/flushed) and an independent negedge monitor.
module tb_if_fetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        jump = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        fetch_stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        id_ready = 1'b0;

    always #5 clk = ~clk;

    if_fetch #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc),
        .jump_flag_i  (jump),
        .req_valid_o  (req_valid),
        .req_addr_o   (req_addr),
        .req_ready_i  (req_ready),
        .rsp_valid_i  (rsp_valid),
        .rsp_data_i   (rsp_data),
        .fetch_stall_o(fetch_stall),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .id_ready_i   (id_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          rdy;   // first cycle the response may be returned
        bit          live;  // cleared when a flush makes it a dropped read
    } mreq_t;

    mreq_t       mem_q[$];  // reads issued to memory, not yet returned
    logic [31:0] exp_q[$];  // addresses owed to decode, in order

    int vectors = 0, miscompares = 0;
    int cyc = 0, n_pop = 0, n_stall = 0, n_acc = 0, last_rdy = 0;
    int k_ready = 100, k_idr = 100, k_jump = 0, k_lmin = 1, k_lmax = 1;
    bit use_tgt = 0;
    logic [31:0] tgt = '0, pc_next = '0, last_pop_addr = '0, last_acc_addr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor: derive expected outputs from the model state, check, and
    // retire the head entry whenever decode takes it.
    always @(negedge clk) begin
        int live_mem, queued;
        bit ev_req, ev_inst;
        live_mem = 0;
        foreach (mem_q[i]) if (mem_q[i].live) live_mem++;
        queued  = exp_q.size() - live_mem;
        ev_req  = !rst && !jump && (mem_q.size() + queued < DEPTH);
        ev_inst = !rst && !jump && (queued > 0);
`ifdef FETCH_BYPASS_EN
        if (!rst && !jump && queued == 0 && rsp_valid && mem_q.size() > 0 && mem_q[0].live)
            ev_inst = 1;
`endif
        chkb("req_valid", req_valid, ev_req);
        if (ev_req) chk("req_addr", req_addr, pc);
        chkb("fetch_stall", fetch_stall, !(ev_req && req_ready));
        chkb("inst_valid", inst_valid, ev_inst);
        if (ev_inst) begin
            chk("inst_addr", inst_addr, exp_q[0]);
            chk("inst", inst, memf(exp_q[0]));
            if (id_ready) begin
                last_pop_addr = exp_q.pop_front();
                n_pop++;
            end
        end else begin
            chk("inst_idle", inst, NOP);
            chk("inst_addr_idle", inst_addr, 32'h0);
        end
        if (fetch_stall) n_stall++;
    end

    // One clock of stimulus followed by the model update for that cycle.
    task automatic step(input bit r);
        @(posedge clk); #1;
        cyc++;
        rst       = r;
        pc        = pc_next;
        req_ready = ($urandom_range(99) < k_ready);
        id_ready  = ($urandom_range(99) < k_idr);
        jump      = !r && ($urandom_range(99) < k_jump);
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
        if (!r && mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = memf(mem_q[0].addr);
        end
        @(negedge clk); #1;
        if (r) begin
            mem_q.delete();
            exp_q.delete();
            pc_next  = '0;
            last_rdy = 0;
        end else begin
            if (rsp_valid) void'(mem_q.pop_front());
            if (jump) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].live = 0;
                pc_next = use_tgt ? tgt : (32'($urandom) & 32'hFFFF_FFFC);
            end else if (req_valid && req_ready) begin
                int rdy;
                rdy = cyc + $urandom_range(k_lmax, k_lmin);
                if (rdy <= last_rdy) rdy = last_rdy + 1;
                last_rdy = rdy;
                mem_q.push_back('{addr: pc, rdy: rdy, live: 1'b1});
                exp_q.push_back(pc);
                last_acc_addr = req_addr;
                n_acc++;
                pc_next = pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic drain();
        k_ready = 0; k_idr = 100; k_jump = 0;
        run(15);
    endtask

    initial begin
        int s0, p0, a0;
        logic [31:0] pc_hold;

        // Reset, then streaming with a 1-cycle memory.
        step(1'b1);
        step(1'b1);
        k_ready = 100; k_idr = 100; k_lmin = 1; k_lmax = 1;
        run(2);
        s0 = n_stall; p0 = n_pop;
        run(38);
        chk("stream_stalls", 32'(n_stall - s0), 32'd0);
        chk("stream_pops", 32'(n_pop - p0), 32'd38);

        // Memory stall: PC held, accepted on the 4th cycle unchanged.
        pc_hold = pc_next;
        a0 = n_acc;
        k_ready = 0;
        run(3);
        chk("mstall_acc", 32'(n_acc - a0), 32'd0);
        k_ready = 100;
        run(1);
        chk("mstall_acc4", 32'(n_acc - a0), 32'd1);
        chk("mstall_addr", last_acc_addr, pc_hold);

        // Backpressure: exactly DEPTH accepts, then drain in order.
        drain();
        a0 = n_acc;
        k_ready = 100; k_idr = 0;
        run(10);
        chk("bp_accepts", 32'(n_acc - a0), 32'(DEPTH));
        k_idr = 100;
        run(10);

        // Flush with 2 queued and 2 in flight, redirect to 0x100.
        drain();
        k_ready = 100; k_idr = 0; k_lmin = 4; k_lmax = 4;
        run(6);
        k_jump = 100; use_tgt = 1; tgt = 32'h100;
        run(1);
        k_jump = 0; use_tgt = 0; k_idr = 100; k_lmin = 1; k_lmax = 1;
        p0 = n_pop;
        for (int i = 0; i < 20 && n_pop == p0; i++) step(1'b0);
        chk("flush_pops", 32'(n_pop > p0), 32'd1);
        chk("flush_first", last_pop_addr, 32'h100);

        // Random traffic with jumps, variable latency and a mid-run reset.
        k_ready = 70; k_idr = 70; k_jump = 5; k_lmin = 1; k_lmax = 4;
        run(1500);
        step(1'b1);
        run(300);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
